// File: rtl/alu_arbiter_pkg.sv
// Shared types and constants for the ALU arbiter: FSM state, ALU control/flag widths,
// requester-count bound and a lowest-set-bit helper used by the grant selector.
package alu_arbiter_pkg;

  localparam int ALU_CTRL_W  = 3;
  localparam int ALU_FLAGS_W = 4;
  localparam int NREQ_MAX    = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  // Two's-complement trick: v & -v keeps only the lowest set bit.
  function automatic logic [NREQ_MAX-1:0] lowest_one(input logic [NREQ_MAX-1:0] v);
    return v & (~v + NREQ_MAX'(1));
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester-side handshakes plus the ALU operand/result bus of the arbiter.
// slave = arbiter view, master = requesters and ALU driving the arbiter.
interface alu_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int NREQ  = 4
);
  import alu_arbiter_pkg::*;

  logic [NREQ-1:0]                 req_valid;
  logic [NREQ-1:0]                 req_ready;
  logic [NREQ-1:0][WIDTH-1:0]      req_op1;
  logic [NREQ-1:0][WIDTH-1:0]      req_op2;
  logic [NREQ-1:0][ALU_CTRL_W-1:0] req_ctrl;
  logic [NREQ-1:0]                 rsp_valid;
  logic [NREQ-1:0]                 rsp_ready;
  logic [WIDTH-1:0]                rsp_result;
  logic [ALU_FLAGS_W-1:0]          rsp_flags;
  logic [WIDTH-1:0]                alu_op1;
  logic [WIDTH-1:0]                alu_op2;
  logic [ALU_CTRL_W-1:0]           alu_control;
  logic [WIDTH-1:0]                alu_result;
  logic [ALU_FLAGS_W-1:0]          alu_flags;

  modport slave (
    input  req_valid, req_op1, req_op2, req_ctrl, rsp_ready, alu_result, alu_flags,
    output req_ready, rsp_valid, rsp_result, rsp_flags, alu_op1, alu_op2, alu_control
  );

  modport master (
    output req_valid, req_op1, req_op2, req_ctrl, rsp_ready, alu_result, alu_flags,
    input  req_ready, rsp_valid, rsp_result, rsp_flags, alu_op1, alu_op2, alu_control
  );

endinterface

// File: rtl/alu_grant_sel.sv
// Combinational one-hot grant. ALU_ARBITER_RR_EN selects round-robin after the one-hot
// last-grant pointer; otherwise fixed priority with the lowest index winning.
module alu_grant_sel
  import alu_arbiter_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0] req_valid_i,
`ifdef ALU_ARBITER_RR_EN
  input  logic [NREQ-1:0] ptr_i,
`endif
  output logic [NREQ-1:0] grant_o
);

`ifdef ALU_ARBITER_RR_EN
  logic [NREQ-1:0] above_ptr;
  logic [NREQ-1:0] upper_req;
  logic [NREQ-1:0] search;

  // Bits strictly above the pointer; empty when the pointer sits on the top requester.
  assign above_ptr = ~((ptr_i << 1) - NREQ'(1));
  assign upper_req = req_valid_i & above_ptr;
  assign search    = (|upper_req) ? upper_req : req_valid_i;
  assign grant_o   = NREQ'(lowest_one(NREQ_MAX'(search)));
`else
  assign grant_o   = NREQ'(lowest_one(NREQ_MAX'(req_valid_i)));
`endif

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU among NREQ requesters: accept, drive ALU, capture, respond.
// ALU_ARBITER_RR_EN enables round-robin arbitration with a last-grant pointer.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREQ  = 4
) (
  input  logic          clk,
  input  logic          reset,
  alu_arbiter_if.slave  bus
);

  localparam int SEL_W = 2 * WIDTH + ALU_CTRL_W;

  arb_state_t             state_q, state_d;
  logic [NREQ-1:0]        grant;
  logic [NREQ-1:0]        gnt_q;
  logic [NREQ-1:0]        rsp_valid_q;
  logic [WIDTH-1:0]       alu_op1_q, alu_op2_q, rsp_result_q;
  logic [ALU_CTRL_W-1:0]  alu_ctrl_q;
  logic [ALU_FLAGS_W-1:0] rsp_flags_q;
  logic [SEL_W-1:0][NREQ-1:0] sel_cols;
  logic [SEL_W-1:0]       sel_word;
  logic                   accept;
  logic                   rsp_done;

`ifdef ALU_ARBITER_RR_EN
  logic [NREQ-1:0]        ptr_q;
`endif

  alu_grant_sel #(.NREQ(NREQ)) u_grant_sel (
    .req_valid_i (bus.req_valid),
`ifdef ALU_ARBITER_RR_EN
    .ptr_i       (ptr_q),
`endif
    .grant_o     (grant)
  );

  // AND-OR operand mux keyed by the one-hot grant, built bit-column by bit-column.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
    logic [SEL_W-1:0] req_word;
    assign req_word = {bus.req_ctrl[gi], bus.req_op2[gi], bus.req_op1[gi]};
    for (genvar gb = 0; gb < SEL_W; gb++) begin : g_bit
      assign sel_cols[gb][gi] = grant[gi] & req_word[gb];
    end
  end

  for (genvar gb = 0; gb < SEL_W; gb++) begin : g_or
    assign sel_word[gb] = |sel_cols[gb];
  end

  assign accept   = |(bus.req_valid & bus.req_ready);
  assign rsp_done = |(rsp_valid_q & bus.rsp_ready);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)   state_d = EXEC;
      EXEC:                  state_d = RESP;
      RESP:    if (rsp_done) state_d = IDLE;
      default:               state_d = IDLE;
    endcase
  end

  // Grant is only offered while idle and out of reset.
  always_comb begin
    bus.req_ready = '0;
    if (reset && state_q == IDLE) begin
      bus.req_ready = grant;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      gnt_q        <= '0;
      rsp_valid_q  <= '0;
      alu_op1_q    <= '0;
      alu_op2_q    <= '0;
      alu_ctrl_q   <= '0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
    end else begin
      if (accept) begin
        {alu_ctrl_q, alu_op2_q, alu_op1_q} <= sel_word;
        gnt_q <= bus.req_ready;
      end
      if (state_q == EXEC) begin
        rsp_result_q <= bus.alu_result;
        rsp_flags_q  <= bus.alu_flags;
        rsp_valid_q  <= gnt_q;
      end else if (rsp_done) begin
        rsp_valid_q  <= '0;
      end
    end
  end

`ifdef ALU_ARBITER_RR_EN
  // Starting on the top requester makes requester 0 first after reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr_q <= NREQ'(1) << (NREQ - 1);
    end else if (rsp_done) begin
      ptr_q <= gnt_q;
    end
  end
`endif

  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_result  = rsp_result_q;
  assign bus.rsp_flags   = rsp_flags_q;
  assign bus.alu_op1     = alu_op1_q;
  assign bus.alu_op2     = alu_op2_q;
  assign bus.alu_control = alu_ctrl_q;

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one combinational ALU among NREQ requesters (scalar pipeline, vector lanes, address helper) behind per-requester valid/ready handshakes. Arbitrates, registers the winning operand set onto the ALU inputs, captures result and flags one cycle later, and returns them to the winning requester only. Sits between the core's execute-side requesters and the single `alu` instance.

## Interface
- `WIDTH`, default 32: operand and result width, same value as the ALU's `WIDTH`.
- `NREQ`, default 4: number of requesters, 2..8.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-low; sampled on the `clk` rising edge.
- `req_valid` in [NREQ]: requester i has an operation pending.
- `req_ready` out [NREQ]: one-hot grant/accept; a transfer occurs when `req_valid[i] & req_ready[i]`.
- `req_op1`, `req_op2` in [NREQ][WIDTH]: per-requester operands.
- `req_ctrl` in [NREQ][3]: per-requester ALU control code, passed through unchanged.
- `rsp_valid` out [NREQ]: one-hot; result is available for requester i.
- `rsp_ready` in [NREQ]: requester i consumes the response.
- `rsp_result` out WIDTH: shared response data.
- `rsp_flags` out 4: shared response flags, exactly as the ALU produced them.
- `alu_op1`, `alu_op2` out WIDTH: to the ALU `op1`/`op2`.
- `alu_control` out 3: to the ALU `alu_control`.
- `alu_result` in WIDTH: from the ALU `result`.
- `alu_flags` in 4: from the ALU `flags`.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE
  - The arbiter picks grant index g among asserted `req_valid`.
  - `req_ready[g]`=1, combinational from `req_valid` and the priority pointer.
  - On transfer: capture `req_op1[g]`, `req_op2[g]` and `req_ctrl[g]` into the `alu_*` registers, record g, go to EXEC.
  - No valid requests: stay in IDLE.
- EXEC
  - The ALU evaluates the held inputs.
  - At the end of the cycle: capture `alu_result` and `alu_flags` into `rsp_result`/`rsp_flags`, then go to RESP.
- RESP
  - `rsp_valid[g]`=1.
  - When `rsp_ready[g]`=1: clear `rsp_valid`, update the priority pointer to g, go to IDLE.
  - `rsp_ready` of other requesters is ignored.
- `req_ready` is all-zero outside IDLE.
- `alu_*` registers hold their last values outside the capture cycle. No ALU toggling when idle.
- `rsp_result`/`rsp_flags` hold their values after the handshake until the next capture.
- Requesters hold `req_valid` and their operands until accepted. Dropping `req_valid` before acceptance is legal and simply removes the request from arbitration.
- The same requester may win consecutive transactions if it is the only one requesting.
- Reset (`reset`=0) mid-operation: the in-flight transaction is discarded with no response.
  - FSM returns to IDLE.
  - Priority pointer is set to NREQ-1, so requester 0 has first priority.
  - All outputs go to 0 on the next edge.

## Timing
- Reset values: `req_ready`, `rsp_valid`, `rsp_result`, `rsp_flags`, `alu_op1`, `alu_op2` and `alu_control` are all 0. `req_ready` is 0 during reset even if `req_valid` is high.
- Accept on cycle N → `alu_*` valid in N+1 → `rsp_valid` rises in N+2.
- Response accepted in cycle M → earliest next accept in M+1. Minimum 3 cycles per operation.
- `req_ready` depends combinationally on `req_valid` only, never on `rsp_ready`.
- All other outputs are registered.

## Configuration
- `ALU_ARBITER_RR_EN` defined: round-robin.
  - Search order starts at (last grant + 1) mod NREQ and wraps past NREQ-1 to 0.
  - Pointer updates on each completed response.
- `ALU_ARBITER_RR_EN` undefined: fixed priority, lowest index wins.
  - The pointer register is not implemented.
  - Requester 0 can starve the others, by design for the scalar pipeline.

## Structure
- `alu_arbiter_pkg` contains:
  - the state enum `arb_state_t` (IDLE, EXEC, RESP);
  - constants `ALU_CTRL_W`=3 and `ALU_FLAGS_W`=4;
  - the `NREQ` upper bound of 8.
- One sub-module, `alu_grant_sel`: combinational one-hot grant from `req_valid` and pointer, with round-robin or fixed priority selected by the macro.
- FSM, capture registers and muxing stay in `alu_arbiter`.

## Test plan
Bench settings: WIDTH=4, NREQ=2, stub ALU returning `op1+op2` truncated to 4 bits with flags {N,Z,C,V}.
- Single request: requester 0 sends 0111+0001, ctrl 000 → accepted cycle 0, `alu_op1`=0111 in cycle 1, `rsp_valid[0]` in cycle 2 with result 1000 and flags N=1, V=1; cleared the cycle after `rsp_ready[0]`.
- Both requesters valid from reset → requester 0 granted first. Then:
  - RR build: requester 1 is granted next.
  - Fixed build: requester 0 is granted again while it keeps requesting.
- Response backpressure: hold `rsp_ready`=0 for 5 cycles with requester 1 valid → `rsp_valid` and result stay stable, `req_ready` stays 00, no new ALU inputs.
- Carry/zero: 1111+0001 → result 0000, Z=1, C=1, returned only on the granted requester's `rsp_valid`.
- Reset in EXEC: assert `reset`=0 one cycle after accept → next edge all outputs 0, no `rsp_valid`, requester 0 has priority afterwards.
- Withdrawn request: requester 1 raises then drops `req_valid` before its grant → no `req_ready[1]`, no response.
